// File: rtl/md_pkg.sv
// Shared encodings, state type and widths for the multiply/divide controller.
// The divider is only built when MULDIV_DIV_EN is defined.
package md_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } md_hilo_t;

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit product and {remainder, quotient} generator.
// Divider half exists only when MULDIV_DIV_EN is defined.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output md_hilo_t          res_c,
    output logic              div_zero_c
);

    logic [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0] prod_u;

    assign prod_s = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    assign prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

`ifdef MULDIV_DIV_EN
    logic [DATA_W-1:0] b_safe;
    logic [DATA_W-1:0] quo_s;
    logic [DATA_W-1:0] rem_s;
    logic [DATA_W-1:0] quo_u;
    logic [DATA_W-1:0] rem_u;

    // Zero divisor is replaced so the dividers never see it; the result is discarded anyway.
    assign b_safe = (b == '0) ? DATA_W'(1) : b;
    assign quo_s  = DATA_W'($signed(a) / $signed(b_safe));
    assign rem_s  = DATA_W'($signed(a) % $signed(b_safe));
    assign quo_u  = a / b_safe;
    assign rem_u  = a % b_safe;
`endif

    always_comb begin
        res_c      = '0;
        div_zero_c = 1'b0;
        case (op)
            MD_MULT:  res_c = prod_s;
            MD_MULTU: res_c = prod_u;
`ifdef MULDIV_DIV_EN
            MD_DIV: begin
                res_c.hi   = rem_s;
                res_c.lo   = quo_s;
                div_zero_c = (b == '0);
            end
            MD_DIVU: begin
                res_c.hi   = rem_u;
                res_c.lo   = quo_u;
                div_zero_c = (b == '0);
            end
`endif
            default: res_c = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and latency model for the multi-cycle multiply/divide unit.
// DIV/DIVU are only accepted when MULDIV_DIV_EN is defined; otherwise they are NOPs.
module muldiv_ctrl
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              md_use_d,
    output logic              busy,
    output logic              stall,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    md_hilo_t          pend_q, pend_d;
    logic              dz_q, dz_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              busy_q;

    md_hilo_t          res_c;
    logic              div_zero_c;
    logic              is_mult_c;
    logic              is_div_c;
    logic              launch_c;

    md_arith u_arith (
        .op         (op),
        .a          (a),
        .b          (b),
        .res_c      (res_c),
        .div_zero_c (div_zero_c)
    );

    assign is_mult_c = (op == MD_MULT) || (op == MD_MULTU);
    assign is_div_c  = (op == MD_DIV)  || (op == MD_DIVU);
`ifdef MULDIV_DIV_EN
    assign launch_c  = is_mult_c || is_div_c;
`else
    assign launch_c  = is_mult_c;
`endif

    // Next-state: launch/immediate writes in IDLE, countdown and commit in BUSY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op == MD_MTHI) begin
                        hi_d = a;
                    end else if (op == MD_MTLO) begin
                        lo_d = a;
                    end else if (launch_c) begin
                        pend_d  = res_c;
                        dz_d    = div_zero_c;
                        cnt_d   = is_div_c ? DIV_LOAD : MULT_LOAD;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (!dz_q) begin
                        hi_d = pend_q.hi;
                        lo_d = pend_q.lo;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (state_d == BUSY);
        end
    end

    assign busy  = busy_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    // Zero-latency hazard request toward D.
    assign stall = md_use_d & (start | busy_q);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: driver queues expected results, monitor checks on completion.
// Expectations follow MULDIV_DIV_EN when it is defined for the build.
module tb_muldiv_ctrl;
    import md_pkg::*;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif
    localparam int DIVC = DIV_ON ? 10 : 0;

    typedef struct {
        string       name;
        int          cyc;
        int          stl;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_d;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    exp_t exp_q[$];
    int   total    = 0;
    int   bad      = 0;
    int   done_cnt = 0;

    muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .md_use_d (md_use_d),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic wait_done(input string nm, input int target);
        int k;
        k = 0;
        while (done_cnt < target && k < 100) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (done_cnt < target) begin
            bad++;
            $display("FAIL %s.timeout: got done=%0d expected %0d", nm, done_cnt, target);
        end
    endtask

    task automatic issue(input string nm, input logic [2:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic use_d, input int cyc,
                         input int stl, input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        int   target;
        e.name = nm; e.cyc = cyc; e.stl = stl; e.hi = ehi; e.lo = elo;
        exp_q.push_back(e);
        target = done_cnt + 1;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv; md_use_d = use_d;
        @(negedge clk);
        start = 1'b0;
        wait_done(nm, target);
        md_use_d = 1'b0;
    endtask

    // Monitor: measures busy length and stall cycles per accepted start, then scores HI/LO.
    initial begin
        exp_t e;
        int   n;
        int   ns;
        forever begin
            @(posedge clk);
            if (start && reset) begin
                ns = stall ? 1 : 0;
                n  = 0;
                #1;
                while (busy && n < 64) begin
                    n++;
                    @(posedge clk);
                    if (stall) ns++;
                    #1;
                end
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL monitor.unexpected: got completion expected none");
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, ".cycles"}, 64'(n), 64'(e.cyc));
                    chk({e.name, ".stall"},  64'(ns), 64'(e.stl));
                    chk({e.name, ".hi"},     64'(hi), 64'(e.hi));
                    chk({e.name, ".lo"},     64'(lo), 64'(e.lo));
                end
                done_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   target;
        reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; md_use_d = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset.busy",  64'(busy),  64'd0);
        chk("reset.hi",    64'(hi),    64'd0);
        chk("reset.lo",    64'(lo),    64'd0);
        chk("reset.stall", 64'(stall), 64'd0);
        md_use_d = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        issue("mthi",     MD_MTHI,  32'h1111, 32'h0, 1'b0, 0, 0, 32'h1111, 32'h0);
        issue("mtlo",     MD_MTLO,  32'h2222, 32'h0, 1'b0, 0, 0, 32'h1111, 32'h2222);
        issue("mult_neg", MD_MULT,  32'hFFFFFFFD, 32'd7, 1'b0, 5, 0, 32'hFFFFFFFF, 32'hFFFFFFEB);
        issue("divu",     MD_DIVU,  32'd100, 32'd7, 1'b0, DIVC, 0,
              DIV_ON ? 32'd2 : 32'hFFFFFFFF, DIV_ON ? 32'd14 : 32'hFFFFFFEB);
        issue("div_neg",  MD_DIV,   32'hFFFFFFF9, 32'd2, 1'b0, DIVC, 0,
              32'hFFFFFFFF, DIV_ON ? 32'hFFFFFFFD : 32'hFFFFFFEB);
        issue("mthi2",    MD_MTHI,  32'h1111, 32'h0, 1'b0, 0, 0, 32'h1111,
              DIV_ON ? 32'hFFFFFFFD : 32'hFFFFFFEB);
        issue("mtlo2",    MD_MTLO,  32'h2222, 32'h0, 1'b0, 0, 0, 32'h1111, 32'h2222);
        issue("div_zero", MD_DIV,   32'd5, 32'd0, 1'b0, DIVC, 0, 32'h1111, 32'h2222);
        issue("multu_st", MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b1, 5, 6, 32'h1, 32'hFFFFFFFE);
        issue("mthi_st",  MD_MTHI,  32'h5, 32'h0, 1'b1, 0, 1, 32'h5, 32'hFFFFFFFE);
        issue("undef_op", 3'd7,     32'h9, 32'h9, 1'b0, 0, 0, 32'h5, 32'hFFFFFFFE);
        issue("mult_m1",  MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5, 0, 32'h0, 32'h1);
        issue("multu_m1", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5, 0, 32'hFFFFFFFE, 32'h1);
        issue("mult_min", MD_MULT,  32'h80000000, 32'h80000000, 1'b0, 5, 0, 32'h40000000, 32'h0);
        issue("div_nb",   MD_DIV,   32'd7, 32'hFFFFFFFE, 1'b0, DIVC, 0,
              DIV_ON ? 32'h1 : 32'h40000000, DIV_ON ? 32'hFFFFFFFD : 32'h0);

        // A start pulse while busy must be ignored.
        e.name = "busy_ign"; e.cyc = 5; e.stl = 0; e.hi = 32'h0; e.lo = 32'hC;
        exp_q.push_back(e);
        target = done_cnt + 1;
        @(negedge clk);
        start = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = MD_MTHI; a = 32'hDEAD;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_ign", target);

        // Reset in the third busy cycle aborts the op with no late commit.
        e.name = "rst_mid"; e.cyc = 3; e.stl = 0; e.hi = 32'h0; e.lo = 32'h0;
        exp_q.push_back(e);
        target = done_cnt + 1;
        @(negedge clk);
        start = 1'b1; op = DIV_ON ? MD_DIV : MD_MULT; a = 32'd100; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid.busy_now", 64'(busy), 64'd0);
        chk("rst_mid.hi_now",   64'(hi),   64'd0);
        chk("rst_mid.lo_now",   64'(lo),   64'd0);
        wait_done("rst_mid", target);
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        chk("rst_mid.busy_late", 64'(busy), 64'd0);
        chk("rst_mid.hi_late",   64'(hi),   64'd0);
        chk("rst_mid.lo_late",   64'(lo),   64'd0);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard.leftover: got %0d expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide controller owning the HI/LO register pair for the five-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from the E stage. It models the iterative latency of the arithmetic unit and commits results into HI/LO on completion. It raises a stall request so any HI/LO-touching instruction in D is held until the unit is free.

## Interface
Parameters:
- MULT_CYCLES, 5, cycles a MULT/MULTU occupies the unit (≥1)
- DIV_CYCLES, 10, cycles a DIV/DIVU occupies the unit (≥1)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  E-stage instruction is a muldiv op; sampled at rising edge
- op  in  3  operation code (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO)
- a  in  32  forwarded rs operand from E
- b  in  32  forwarded rt operand from E
- md_use_d  in  1  instruction in D is mult/div/mfhi/mflo/mthi/mtlo
- busy  out  1  unit occupied, registered
- stall  out  1  pipeline stall request = md_use_d & (start | busy)
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, BUSY. Down-counter cnt, wide enough for max(MULT_CYCLES, DIV_CYCLES).
- IDLE with start=1:
  - MTHI: hi←a. MTLO: lo←a. Both complete in one edge, no BUSY.
  - MULT: signed 64-bit a×b is latched into a pending register; cnt←MULT_CYCLES; go BUSY.
  - MULTU: unsigned 64-bit a×b is latched the same way; cnt←MULT_CYCLES; go BUSY.
  - DIV/DIVU: pending = {remainder, quotient} (signed/unsigned, remainder sign follows dividend); cnt←DIV_CYCLES; go BUSY.
  - Divide by zero: BUSY sequence runs normally; on completion HI/LO are left unchanged.
- BUSY: cnt decrements each edge. At the edge where cnt==1: {hi,lo}←pending, go IDLE.
- start while BUSY: ignored, with no state change. The stall guarantees this cannot occur in legal flow.
- Undefined op with start=1: treated as NOP.
- mfhi/mflo read hi/lo directly. They are stalled via md_use_d until busy=0, so no partial results are ever visible.
- Reset (any state, including mid-BUSY): state←IDLE, cnt←0, pending discarded, hi=0, lo=0, busy=0.

## Timing
- Reset values: busy=0, hi=0, lo=0. stall follows its combinational equation.
- start sampled at edge k for an N-cycle op: busy=1 from edge k to edge k+N. HI/LO take new values at edge k+N; busy=0 at edge k+N.
- A back-to-back muldiv op in D sees stall=1 in the start cycle and the N busy cycles. It enters E on the cycle busy=0.
- MTHI/MTLO: hi/lo updated at edge k; busy stays 0. A following mfhi in D stalls only during the start cycle.
- stall is combinational from start, busy and md_use_d, with zero latency.

## Configuration
- MULDIV_DIV_EN defined: DIV/DIVU are implemented as above.
- MULDIV_DIV_EN undefined: no divider logic is built. DIV/DIVU with start=1 are NOPs: no BUSY, HI/LO unchanged. The DIV_CYCLES parameter is unused.

## Structure
- Shared package md_pkg holds:
  - op encodings (MD_MULT=3'd0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5)
  - state enum (IDLE, BUSY)
  - counter width constant
- One sub-module, md_arith: combinational 64-bit product / quotient-remainder generator, with the divider half under MULDIV_DIV_EN. muldiv_ctrl holds the FSM, counter, pending register and HI/LO.

## Test plan
- MULT a=-3, b=7, start at edge k -> busy=1 for 5 cycles; at edge k+5, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- DIVU a=100, b=7 -> busy for 10 cycles; then lo=14, hi=2. DIV a=-7, b=2 -> lo=-3, hi=-1.
- DIV by b=0 with hi/lo preloaded 32'h1111/32'h2222 via MTHI/MTLO -> busy for 10 cycles; hi/lo unchanged.
- MULTU 32'hFFFFFFFF×2 followed immediately by mflo in D (md_use_d=1) -> stall=1 for 6 cycles; mflo then sees lo=32'hFFFFFFFE, hi=1.
- Reset driven low at cycle 3 of a DIV -> busy=0, hi=lo=0 immediately; after release, no late commit.
- MULDIV_DIV_EN undefined, DIV start -> busy stays 0, hi/lo unchanged.
